// File: rtl/bresolve.sv
// Branch resolution tracker: queues fetch predictions, checks them against in-order
// execute outcomes, writes the predictor and redirects fetch on mispredict.
// Optional saturating statistics counters are enabled by defining BRESOLVE_STATS_EN.
module bresolve #(
    parameter int DEPTH_BITS = 2,
    parameter int SIZE_ADDR  = 32
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic                  iw_pred_valid,
    input  logic [SIZE_ADDR-1:0]  iw_pred_pc,
    input  logic                  iw_pred_taken,
    input  logic [SIZE_ADDR-1:0]  iw_pred_target,
    output logic                  ow_pred_ready,
    input  logic                  iw_res_valid,
    input  logic                  iw_res_taken,
    input  logic [SIZE_ADDR-1:0]  iw_res_target,
    output logic                  ow_update,
    output logic [SIZE_ADDR-1:0]  ow_update_pc,
    output logic                  ow_actual_taken,
    output logic [SIZE_ADDR-1:0]  ow_actual_target,
    output logic                  ow_redirect,
    output logic [SIZE_ADDR-1:0]  ow_redirect_pc,
`ifdef BRESOLVE_STATS_EN
    output logic [15:0]           ow_branch_count,
    output logic [15:0]           ow_mispredict_count,
`endif
    output logic [DEPTH_BITS:0]   ow_count
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] LP_DEPTH = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [SIZE_ADDR-1:0] LP_ONE = SIZE_ADDR'(1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                 r_state;
    logic [SIZE_ADDR-1:0]   r_pc_mem     [DEPTH];
    logic                   r_taken_mem  [DEPTH];
    logic [SIZE_ADDR-1:0]   r_target_mem [DEPTH];
    logic [DEPTH_BITS-1:0]  r_rd_ptr;
    logic [DEPTH_BITS-1:0]  r_wr_ptr;
    logic [DEPTH_BITS:0]    r_count;

    logic                   r_update;
    logic [SIZE_ADDR-1:0]   r_update_pc;
    logic                   r_actual_taken;
    logic [SIZE_ADDR-1:0]   r_actual_target;
    logic                   r_redirect;
    logic [SIZE_ADDR-1:0]   r_redirect_pc;

    logic                   w_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_mispredict;
    logic [SIZE_ADDR-1:0]   w_entry_pc;
    logic                   w_entry_taken;
    logic [SIZE_ADDR-1:0]   w_entry_target;
    logic [SIZE_ADDR-1:0]   w_fix_pc;

    assign w_entry_pc     = r_pc_mem[r_rd_ptr];
    assign w_entry_taken  = r_taken_mem[r_rd_ptr];
    assign w_entry_target = r_target_mem[r_rd_ptr];

    // A full queue refuses pushes even when a pop frees a slot on the same edge.
    assign w_ready = (r_state == ST_RUN) && (r_count != LP_DEPTH) && !iw_rst;
    assign w_push  = iw_pred_valid && w_ready;
    assign w_pop   = iw_res_valid && (r_count != '0) && (r_state == ST_RUN);

    // Not-taken against not-taken is always correct, regardless of targets.
    assign w_mispredict = w_pop &&
                          ((w_entry_taken != iw_res_taken) ||
                           (iw_res_taken && (w_entry_target != iw_res_target)));

    assign w_fix_pc = iw_res_taken ? iw_res_target : (w_entry_pc + LP_ONE);

    always_ff @(posedge iw_clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]     <= iw_pred_pc;
            r_taken_mem[r_wr_ptr]  <= iw_pred_taken;
            r_target_mem[r_wr_ptr] <= iw_pred_target;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state         <= ST_RUN;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_update        <= 1'b0;
            r_update_pc     <= '0;
            r_actual_taken  <= 1'b0;
            r_actual_target <= '0;
            r_redirect      <= 1'b0;
            r_redirect_pc   <= '0;
        end else begin
            r_update   <= w_pop;
            r_redirect <= w_mispredict;
            if (w_pop) begin
                r_update_pc     <= w_entry_pc;
                r_actual_taken  <= iw_res_taken;
                r_actual_target <= iw_res_target;
            end
            if (w_mispredict) begin
                // Everything younger than the mispredicted branch is on the wrong path.
                r_redirect_pc <= w_fix_pc;
                r_state       <= ST_FLUSH;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_count       <= '0;
            end else begin
                r_state <= ST_RUN;
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

`ifdef BRESOLVE_STATS_EN
    logic [15:0] r_branch_count;
    logic [15:0] r_mispredict_count;

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_pop && (r_branch_count != 16'hFFFF)) begin
                r_branch_count <= r_branch_count + 16'd1;
            end
            if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
        end
    end

    assign ow_branch_count     = r_branch_count;
    assign ow_mispredict_count = r_mispredict_count;
`endif

    assign ow_pred_ready    = w_ready;
    assign ow_update        = r_update;
    assign ow_update_pc     = r_update_pc;
    assign ow_actual_taken  = r_actual_taken;
    assign ow_actual_target = r_actual_target;
    assign ow_redirect      = r_redirect;
    assign ow_redirect_pc   = r_redirect_pc;
    assign ow_count         = r_count;

endmodule

// File: tb/tb_bresolve.sv
// Directed, table-driven bench for bresolve: per-cycle vectors with hand-computed
// expectations, plus hand-written reset and statistics sequences.
module tb_bresolve;

    localparam int AW = 32;

    logic            iw_clk;
    logic            iw_rst;
    logic            iw_pred_valid;
    logic [AW-1:0]   iw_pred_pc;
    logic            iw_pred_taken;
    logic [AW-1:0]   iw_pred_target;
    logic            ow_pred_ready;
    logic            iw_res_valid;
    logic            iw_res_taken;
    logic [AW-1:0]   iw_res_target;
    logic            ow_update;
    logic [AW-1:0]   ow_update_pc;
    logic            ow_actual_taken;
    logic [AW-1:0]   ow_actual_target;
    logic            ow_redirect;
    logic [AW-1:0]   ow_redirect_pc;
    logic [2:0]      ow_count;
`ifdef BRESOLVE_STATS_EN
    logic [15:0]     ow_branch_count;
    logic [15:0]     ow_mispredict_count;
`endif

    int checks = 0;
    int errors = 0;

    bresolve #(.DEPTH_BITS(2), .SIZE_ADDR(AW)) dut (
        .iw_clk           (iw_clk),
        .iw_rst           (iw_rst),
        .iw_pred_valid    (iw_pred_valid),
        .iw_pred_pc       (iw_pred_pc),
        .iw_pred_taken    (iw_pred_taken),
        .iw_pred_target   (iw_pred_target),
        .ow_pred_ready    (ow_pred_ready),
        .iw_res_valid     (iw_res_valid),
        .iw_res_taken     (iw_res_taken),
        .iw_res_target    (iw_res_target),
        .ow_update        (ow_update),
        .ow_update_pc     (ow_update_pc),
        .ow_actual_taken  (ow_actual_taken),
        .ow_actual_target (ow_actual_target),
        .ow_redirect      (ow_redirect),
        .ow_redirect_pc   (ow_redirect_pc),
`ifdef BRESOLVE_STATS_EN
        .ow_branch_count     (ow_branch_count),
        .ow_mispredict_count (ow_mispredict_count),
`endif
        .ow_count         (ow_count)
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    typedef struct packed {
        logic          pv;
        logic [AW-1:0] ppc;
        logic          pt;
        logic [AW-1:0] ptg;
        logic          rv;
        logic          rt;
        logic [AW-1:0] rtg;
        logic          eUpd;
        logic [AW-1:0] eUpc;
        logic          eUt;
        logic [AW-1:0] eUtg;
        logic          eRed;
        logic [AW-1:0] eRpc;
        logic [2:0]    eCnt;
        logic          eRdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pv, input logic [AW-1:0] ppc, input logic pt,
                                input logic [AW-1:0] ptg, input logic rv, input logic rt,
                                input logic [AW-1:0] rtg, input logic eUpd,
                                input logic [AW-1:0] eUpc, input logic eUt,
                                input logic [AW-1:0] eUtg, input logic eRed,
                                input logic [AW-1:0] eRpc, input logic [2:0] eCnt,
                                input logic eRdy);
        vec_t v;
        v.pv = pv;  v.ppc = ppc;  v.pt = pt;  v.ptg = ptg;
        v.rv = rv;  v.rt = rt;    v.rtg = rtg;
        v.eUpd = eUpd; v.eUpc = eUpc; v.eUt = eUt; v.eUtg = eUtg;
        v.eRed = eRed; v.eRpc = eRpc; v.eCnt = eCnt; v.eRdy = eRdy;
        return v;
    endfunction

    task automatic applyStimulus(input logic pv, input logic [AW-1:0] ppc, input logic pt,
                                 input logic [AW-1:0] ptg, input logic rv, input logic rt,
                                 input logic [AW-1:0] rtg);
        iw_pred_valid  = pv;
        iw_pred_pc     = ppc;
        iw_pred_taken  = pt;
        iw_pred_target = ptg;
        iw_res_valid   = rv;
        iw_res_taken   = rt;
        iw_res_target  = rtg;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic doReset();
        idle();
        iw_rst = 1'b1;
        tick();
        tick();
        iw_rst = 1'b0;
    endtask

`ifdef BRESOLVE_STATS_EN
    // One push, its resolution, then an idle cycle so any flush completes.
    task automatic statPair(input logic [AW-1:0] pc, input logic resTaken);
        applyStimulus(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, resTaken, 32'h0000_0900);
        tick();
        idle();
        tick();
    endtask
`endif

    initial begin
        iw_rst = 1'b1;
        idle();
        tick();
        checkOutput("ready_in_reset", {63'd0, ow_pred_ready}, 64'd0);
        tick();
        checkOutput("reset_update",   {63'd0, ow_update}, 64'd0);
        checkOutput("reset_redirect", {63'd0, ow_redirect}, 64'd0);
        checkOutput("reset_count",    {61'd0, ow_count}, 64'd0);
        checkOutput("reset_upd_pc",   {32'd0, ow_update_pc}, 64'd0);
        checkOutput("reset_red_pc",   {32'd0, ow_redirect_pc}, 64'd0);
        iw_rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", {63'd0, ow_pred_ready}, 64'd1);

        // Fields: push(v,pc,t,tgt) res(v,t,tgt) -> upd(v,pc,t,tgt) red(v,pc) count ready
        // correct taken prediction
        vecs.push_back(mk(1, 32'h10, 1, 32'h40, 0, 0, 0,        0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h40,             1, 32'h10, 1, 32'h40, 0, 0, 3'd0, 1));
        // direction mispredict, then the flush cycle ends
        vecs.push_back(mk(1, 32'h20, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h80,             1, 32'h20, 1, 32'h80, 1, 32'h80, 3'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 3'd0, 1));
        // not-taken fix at the top of the address space wraps to zero
        vecs.push_back(mk(1, 32'hFFFF_FFFF, 1, 32'h5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h123,            1, 32'hFFFF_FFFF, 0, 32'h123, 1, 32'h0, 3'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 3'd0, 1));
        // not-taken vs not-taken with different targets is correct
        vecs.push_back(mk(1, 32'h30, 0, 32'h99, 0, 0, 0,        0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h77,             1, 32'h30, 0, 32'h77, 0, 0, 3'd0, 1));
        // taken vs taken with a different target mispredicts
        vecs.push_back(mk(1, 32'h50, 1, 32'h60, 0, 0, 0,        0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h61,             1, 32'h50, 1, 32'h61, 1, 32'h61, 3'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 3'd0, 1));
        // resolve against an empty queue is ignored
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h200,            0, 0, 0, 0, 0, 0, 3'd0, 1));
        // fill the queue
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(1, 32'h101, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd2, 1));
        vecs.push_back(mk(1, 32'h102, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd3, 1));
        vecs.push_back(mk(1, 32'h103, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd4, 0));
        // push + pop while full: only the pop happens (0x104 is lost)
        vecs.push_back(mk(1, 32'h104, 0, 0, 1, 0, 0,            1, 32'h100, 0, 0, 0, 0, 3'd3, 1));
        vecs.push_back(mk(1, 32'h105, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                  1, 32'h101, 0, 0, 0, 0, 3'd3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                  1, 32'h102, 0, 0, 0, 0, 3'd2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                  1, 32'h103, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                  1, 32'h105, 0, 0, 0, 0, 3'd0, 1));
        // simultaneous push and pop, not full
        vecs.push_back(mk(1, 32'h200, 1, 32'h300, 0, 0, 0,      0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(1, 32'h201, 0, 0, 1, 1, 32'h300,      1, 32'h200, 1, 32'h300, 0, 0, 3'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h7,              1, 32'h201, 0, 32'h7, 0, 0, 3'd0, 1));
        // flush with three queued and a push offered on the mispredict edge
        vecs.push_back(mk(1, 32'h400, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd1, 1));
        vecs.push_back(mk(1, 32'h401, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd2, 1));
        vecs.push_back(mk(1, 32'h402, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 3'd3, 1));
        vecs.push_back(mk(1, 32'h403, 0, 0, 1, 1, 32'h500,      1, 32'h400, 1, 32'h500, 1, 32'h500, 3'd0, 0));
        vecs.push_back(mk(1, 32'h404, 0, 0, 1, 1, 32'h600,      0, 0, 0, 0, 0, 0, 3'd0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h700,            0, 0, 0, 0, 0, 0, 3'd0, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pv, vecs[i].ppc, vecs[i].pt, vecs[i].ptg,
                          vecs[i].rv, vecs[i].rt, vecs[i].rtg);
            tick();
            checkOutput($sformatf("v%0d_update", i),   {63'd0, ow_update}, {63'd0, vecs[i].eUpd});
            checkOutput($sformatf("v%0d_redirect", i), {63'd0, ow_redirect}, {63'd0, vecs[i].eRed});
            checkOutput($sformatf("v%0d_count", i),    {61'd0, ow_count}, {61'd0, vecs[i].eCnt});
            checkOutput($sformatf("v%0d_ready", i),    {63'd0, ow_pred_ready}, {63'd0, vecs[i].eRdy});
            if (vecs[i].eUpd) begin
                checkOutput($sformatf("v%0d_upd_pc", i),  {32'd0, ow_update_pc}, {32'd0, vecs[i].eUpc});
                checkOutput($sformatf("v%0d_upd_tk", i),  {63'd0, ow_actual_taken}, {63'd0, vecs[i].eUt});
                checkOutput($sformatf("v%0d_upd_tgt", i), {32'd0, ow_actual_target}, {32'd0, vecs[i].eUtg});
            end
            if (vecs[i].eRed) begin
                checkOutput($sformatf("v%0d_red_pc", i), {32'd0, ow_redirect_pc}, {32'd0, vecs[i].eRpc});
            end
        end

        // Data outputs hold the last pulse's values.
        checkOutput("hold_upd_pc",  {32'd0, ow_update_pc}, 64'h400);
        checkOutput("hold_upd_tgt", {32'd0, ow_actual_target}, 64'h500);
        checkOutput("hold_upd_tk",  {63'd0, ow_actual_taken}, 64'd1);
        checkOutput("hold_red_pc",  {32'd0, ow_redirect_pc}, 64'h500);

        // Reset with two entries queued and a resolve pending discards everything.
        applyStimulus(1'b1, 32'h600, 1'b1, 32'h610, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b1, 32'h601, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        checkOutput("pre_reset_count", {61'd0, ow_count}, 64'd2);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        iw_rst = 1'b1;
        tick();
        checkOutput("rst_q_count",    {61'd0, ow_count}, 64'd0);
        checkOutput("rst_q_update",   {63'd0, ow_update}, 64'd0);
        checkOutput("rst_q_redirect", {63'd0, ow_redirect}, 64'd0);
        checkOutput("rst_q_ready",    {63'd0, ow_pred_ready}, 64'd0);
        checkOutput("rst_q_upd_pc",   {32'd0, ow_update_pc}, 64'd0);
        iw_rst = 1'b0;
        tick();
        checkOutput("post_rst_update", {63'd0, ow_update}, 64'd0);
        checkOutput("post_rst_redir",  {63'd0, ow_redirect}, 64'd0);
        checkOutput("post_rst_count",  {61'd0, ow_count}, 64'd0);

`ifdef BRESOLVE_STATS_EN
        doReset();
        checkOutput("stats_reset_br", {48'd0, ow_branch_count}, 64'd0);
        statPair(32'h700, 1'b0);
        statPair(32'h701, 1'b1);
        statPair(32'h702, 1'b0);
        statPair(32'h703, 1'b1);
        statPair(32'h704, 1'b0);
        checkOutput("stats_branches",    {48'd0, ow_branch_count}, 64'd5);
        checkOutput("stats_mispredicts", {48'd0, ow_mispredict_count}, 64'd2);
        applyStimulus(1'b1, 32'h710, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("stats_queued", {61'd0, ow_count}, 64'd2);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h1);
        iw_rst = 1'b1;
        tick();
        iw_rst = 1'b0;
        checkOutput("stats_rst_br",   {48'd0, ow_branch_count}, 64'd0);
        checkOutput("stats_rst_mp",   {48'd0, ow_mispredict_count}, 64'd0);
        checkOutput("stats_rst_cnt",  {61'd0, ow_count}, 64'd0);
        checkOutput("stats_rst_upd",  {63'd0, ow_update}, 64'd0);
        checkOutput("stats_rst_red",  {63'd0, ow_redirect}, 64'd0);
        tick();
        checkOutput("stats_after_upd", {63'd0, ow_update}, 64'd0);
        checkOutput("stats_after_br",  {48'd0, ow_branch_count}, 64'd0);
`else
        doReset();
        checkOutput("final_reset_count", {61'd0, ow_count}, 64'd0);
`endif

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
